// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: shared types plus the bundle of request/response and
// ALU-side signals used by the iterative multiplier sequencer.
//
// Package alu_mul_pkg:
//   bus32_t  - 32-bit data word
//   alu_op_t - ALU operation code (ADD, SLL, SRL)
//
// Interface alu_mul_seq_if signals:
//   flush_i       abort the current operation
//   req_valid_i   request valid          req_ready_o   request can be accepted
//   op_a_i        multiplicand           op_b_i        multiplier
//   resp_valid_o  result valid           resp_ready_i  consumer takes result
//   result_o      product[31:0]          busy_o        sequencer owns the ALU
//   alu_rs1_o     ALU operand 1          alu_rs2_o     ALU operand 2
//   alu_op_o      ALU operation          alu_rd_i      ALU result (combinational)
// Modports: slave = the sequencer, master = requester plus ALU side.

package alu_mul_pkg;
  typedef logic [31:0] bus32_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SLL = 2'd1,
    ALU_SRL = 2'd2
  } alu_op_t;
endpackage

interface alu_mul_seq_if;
  import alu_mul_pkg::*;

  logic    flush_i;
  logic    req_valid_i;
  logic    req_ready_o;
  bus32_t  op_a_i;
  bus32_t  op_b_i;
  logic    resp_valid_o;
  logic    resp_ready_i;
  bus32_t  result_o;
  logic    busy_o;
  bus32_t  alu_rs1_o;
  bus32_t  alu_rs2_o;
  alu_op_t alu_op_o;
  bus32_t  alu_rd_i;

  modport slave (
    input  flush_i, req_valid_i, op_a_i, op_b_i, resp_ready_i, alu_rd_i,
    output req_ready_o, resp_valid_o, result_o, busy_o,
           alu_rs1_o, alu_rs2_o, alu_op_o
  );

  modport master (
    output flush_i, req_valid_i, op_a_i, op_b_i, resp_ready_i, alu_rd_i,
    input  req_ready_o, resp_valid_o, result_o, busy_o,
           alu_rs1_o, alu_rs2_o, alu_op_o
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier producing the low 32 bits of a
// 32x32 product. It has no arithmetic of its own: every cycle of an
// operation it presents one ADD, SLL or SRL to the shared ALU and captures
// the combinational result on the following clock edge.
//
// Ports:
//   clk_i   clock
//   rstn_i  asynchronous active-low reset
//   bus     alu_mul_seq_if.slave (request/response handshake, flush, ALU side)
// Parameter:
//   EARLY_EXIT  1 = stop once the remaining multiplier is zero,
//               0 = always run 32 iterations

module alu_mul_seq
  import alu_mul_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  alu_mul_seq_if.slave       bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_SLL  = 3'd2,
    ST_SRL  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t  state;
  bus32_t  acc;
  bus32_t  mcand;
  bus32_t  mplier;
  logic [5:0] iter;

  logic    req_ready;
  logic    resp_valid;
  logic    busy;
  alu_op_t alu_op;
  bus32_t  alu_rs1;
  bus32_t  alu_rs2;

  // All outputs are registered. The ALU operands for the next state are
  // loaded on the same edge that enters that state, using register values
  // that the entered state's predecessor leaves untouched (e.g. ADD never
  // modifies mcand, so SLL can be given mcand while leaving ADD).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      iter       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
    end else if (bus.flush_i) begin
      // Flush beats everything, including a request seen in IDLE.
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            mcand     <= bus.op_a_i;
            mplier    <= bus.op_b_i;
            acc       <= '0;
            iter      <= '0;
            req_ready <= 1'b0;
            if (EARLY_EXIT && (bus.op_b_i == '0)) begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
            end else begin
              // First ADD sees the freshly cleared accumulator.
              state   <= ST_ADD;
              busy    <= 1'b1;
              alu_op  <= ALU_ADD;
              alu_rs1 <= '0;
              alu_rs2 <= bus.op_a_i;
            end
          end
        end

        ST_ADD: begin
          if (mplier[0]) begin
            acc <= bus.alu_rd_i;
          end
          state   <= ST_SLL;
          alu_op  <= ALU_SLL;
          alu_rs1 <= mcand;
          alu_rs2 <= 32'd1;
        end

        ST_SLL: begin
          mcand   <= bus.alu_rd_i;
          state   <= ST_SRL;
          alu_op  <= ALU_SRL;
          alu_rs1 <= mplier;
          alu_rs2 <= 32'd1;
        end

        ST_SRL: begin
          mplier <= bus.alu_rd_i;
          iter   <= iter + 6'd1;
          if ((EARLY_EXIT && (bus.alu_rd_i == '0)) || (iter == 6'd31)) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            resp_valid <= 1'b1;
            alu_op     <= ALU_ADD;
            alu_rs1    <= '0;
            alu_rs2    <= '0;
          end else begin
            state   <= ST_ADD;
            alu_op  <= ALU_ADD;
            alu_rs1 <= acc;
            alu_rs2 <= mcand;
          end
        end

        ST_DONE: begin
          // Result stays on acc until the consumer takes it.
          if (bus.resp_ready_i) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          alu_op     <= ALU_ADD;
          alu_rs1    <= '0;
          alu_rs2    <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.busy_o       = busy;
  assign bus.result_o     = acc;
  assign bus.alu_op_o     = alu_op;
  assign bus.alu_rs1_o    = alu_rs1;
  assign bus.alu_rs2_o    = alu_rs2;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: self-checking bench for alu_mul_seq. Two instances are
// built, one with early exit and one always running 32 iterations, each
// attached to a small behavioural ALU. Expected products and latencies come
// from plain arithmetic on the operands.

module tb_alu_mul_seq;
  import alu_mul_pkg::*;

  logic clk;
  logic rstn;

  int total = 0;
  int bad   = 0;

  alu_mul_seq_if bus0 ();
  alu_mul_seq_if bus1 ();

  alu_mul_seq #(.EARLY_EXIT(1'b1)) dut0 (.clk_i(clk), .rstn_i(rstn), .bus(bus0));
  alu_mul_seq #(.EARLY_EXIT(1'b0)) dut1 (.clk_i(clk), .rstn_i(rstn), .bus(bus1));

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The shared integer ALU, reduced to the three operations the sequencer uses.
  function automatic logic [31:0] aluRef(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  assign bus0.alu_rd_i = aluRef(bus0.alu_op_o, bus0.alu_rs1_o, bus0.alu_rs2_o);
  assign bus1.alu_rd_i = aluRef(bus1.alu_op_o, bus1.alu_rs1_o, bus1.alu_rs2_o);

  // Reference model: cycle in which resp_valid rises, counted from the
  // request handshake cycle.
  function automatic int expLatency(input logic [31:0] b, input bit earlyExit);
    int k;
    if (!earlyExit) return 97;
    if (b == 32'h0) return 1;
    k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i;
    return 1 + 3 * (k + 1);
  endfunction

  function automatic logic [31:0] expProduct(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'h0, a} * {32'h0, b};
    return full[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic getRespValid(input int sel);
    return (sel == 0) ? bus0.resp_valid_o : bus1.resp_valid_o;
  endfunction
  function automatic logic getReqReady(input int sel);
    return (sel == 0) ? bus0.req_ready_o : bus1.req_ready_o;
  endfunction
  function automatic logic getBusy(input int sel);
    return (sel == 0) ? bus0.busy_o : bus1.busy_o;
  endfunction
  function automatic logic [31:0] getResult(input int sel);
    return (sel == 0) ? bus0.result_o : bus1.result_o;
  endfunction
  function automatic logic [1:0] getAluOp(input int sel);
    return (sel == 0) ? bus0.alu_op_o : bus1.alu_op_o;
  endfunction

  task automatic applyStimulus(input int sel, input logic valid, input logic [31:0] a, input logic [31:0] b);
    if (sel == 0) begin
      bus0.req_valid_i = valid; bus0.op_a_i = a; bus0.op_b_i = b;
    end else begin
      bus1.req_valid_i = valid; bus1.op_a_i = a; bus1.op_b_i = b;
    end
  endtask

  task automatic setRespReady(input int sel, input logic r);
    if (sel == 0) bus0.resp_ready_i = r;
    else          bus1.resp_ready_i = r;
  endtask

  // One full operation, starting and ending on a falling edge. holdCycles
  // keeps resp_ready low that many cycles after resp_valid rises.
  task automatic runOp(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input int expLat,
                       input int holdCycles, input string tag);
    int lat;
    int busyCnt;
    int seqErr;
    logic [1:0] wantOp;
    checkOutput({tag, ".reqReady"}, {31'h0, getReqReady(sel)}, 32'h1);
    applyStimulus(sel, 1'b1, a, b);
    setRespReady(sel, 1'b0);
    @(negedge clk);
    applyStimulus(sel, 1'b0, 32'h0, 32'h0);
    lat = 1;
    busyCnt = 0;
    seqErr = 0;
    while (!getRespValid(sel) && lat < 200) begin
      if (getBusy(sel)) busyCnt++;
      case ((lat - 1) % 3)
        0:       wantOp = ALU_ADD;
        1:       wantOp = ALU_SLL;
        default: wantOp = ALU_SRL;
      endcase
      if (getAluOp(sel) !== wantOp) seqErr++;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".latency"}, lat, expLat);
    checkOutput({tag, ".result"}, getResult(sel), expRes);
    checkOutput({tag, ".busyCycles"}, busyCnt, expLat - 1);
    checkOutput({tag, ".aluSeqErrors"}, seqErr, 32'd0);
    for (int d = 0; d < holdCycles; d++) begin
      @(negedge clk);
      checkOutput({tag, ".holdValid"}, {31'h0, getRespValid(sel)}, 32'h1);
      checkOutput({tag, ".holdResult"}, getResult(sel), expRes);
      checkOutput({tag, ".holdReqReady"}, {31'h0, getReqReady(sel)}, 32'h0);
    end
    setRespReady(sel, 1'b1);
    @(negedge clk);
    setRespReady(sel, 1'b0);
    checkOutput({tag, ".validDropped"}, {31'h0, getRespValid(sel)}, 32'h0);
    checkOutput({tag, ".idleReady"}, {31'h0, getReqReady(sel)}, 32'h1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
    int          sel;
  } vec_t;

  vec_t vecs[6];

  // Main sequence: reset, vector table, hand-written corner cases, random.
  initial begin
    int lat;
    int seen;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{a: 32'd6,          b: 32'd5,          expRes: 32'd30,       expLat: 10, sel: 0};
    vecs[1] = '{a: 32'h12345678,   b: 32'h0,          expRes: 32'h0,        expLat: 1,  sel: 0};
    vecs[2] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   expRes: 32'h00000001, expLat: 97, sel: 0};
    vecs[3] = '{a: 32'h12345678,   b: 32'h0,          expRes: 32'h0,        expLat: 97, sel: 1};
    vecs[4] = '{a: 32'd6,          b: 32'd5,          expRes: 32'd30,       expLat: 97, sel: 1};
    vecs[5] = '{a: 32'h00010000,   b: 32'h00010000,   expRes: 32'h0,        expLat: 52, sel: 0};

    rstn = 1'b0;
    bus0.flush_i = 1'b0; bus1.flush_i = 1'b0;
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 32'h0, 32'h0);
    setRespReady(0, 1'b0);
    setRespReady(1, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("rst.reqReady", {31'h0, bus0.req_ready_o}, 32'h1);
    checkOutput("rst.respValid", {31'h0, bus0.resp_valid_o}, 32'h0);
    checkOutput("rst.busy", {31'h0, bus0.busy_o}, 32'h0);
    checkOutput("rst.result", bus0.result_o, 32'h0);
    checkOutput("rst.aluOp", {30'h0, bus0.alu_op_o}, {30'h0, ALU_ADD});
    checkOutput("rst.rs1", bus0.alu_rs1_o, 32'h0);
    checkOutput("rst.rs2", bus0.alu_rs2_o, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      runOp(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].expRes, vecs[i].expLat, 0,
            $sformatf("vec%0d", i));
    end

    // Consumer stalls for five cycles.
    runOp(0, 32'd7, 32'd3, 32'd21, 7, 5, "hold");

    // Flush in cycle 4 of a long operation.
    applyStimulus(0, 1'b1, 32'd3, 32'h80000000);
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    bus0.flush_i = 1'b1;
    @(negedge clk);
    bus0.flush_i = 1'b0;
    checkOutput("flush.busy", {31'h0, bus0.busy_o}, 32'h0);
    checkOutput("flush.reqReady", {31'h0, bus0.req_ready_o}, 32'h1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus0.resp_valid_o) seen++;
      @(negedge clk);
    end
    checkOutput("flush.noResp", seen, 32'd0);
    runOp(0, 32'd9, 32'd9, 32'd81, 13, 0, "postFlush");

    // Request presented together with flush is ignored.
    applyStimulus(0, 1'b1, 32'd5, 32'd5);
    bus0.flush_i = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    bus0.flush_i = 1'b0;
    checkOutput("flushReq.busy", {31'h0, bus0.busy_o}, 32'h0);
    checkOutput("flushReq.respValid", {31'h0, bus0.resp_valid_o}, 32'h0);

    // Asynchronous reset in cycle 20 of 0xFFFF x 0xFFFF.
    applyStimulus(0, 1'b1, 32'h0000FFFF, 32'h0000FFFF);
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("midRst.busyBefore", {31'h0, bus0.busy_o}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("midRst.reqReady", {31'h0, bus0.req_ready_o}, 32'h1);
    checkOutput("midRst.respValid", {31'h0, bus0.resp_valid_o}, 32'h0);
    checkOutput("midRst.busy", {31'h0, bus0.busy_o}, 32'h0);
    checkOutput("midRst.result", bus0.result_o, 32'h0);
    checkOutput("midRst.aluOp", {30'h0, bus0.alu_op_o}, {30'h0, ALU_ADD});
    checkOutput("midRst.rs1", bus0.alu_rs1_o, 32'h0);
    checkOutput("midRst.rs2", bus0.alu_rs2_o, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    runOp(0, 32'd2, 32'd2, 32'd4, 7, 0, "postRst");

    // Random operands against the arithmetic model; the multiplier is
    // shifted right by a random amount to spread the early-exit latency.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 32 - 1);
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      runOp(0, ra, rb, expProduct(ra, rb), expLatency(rb, 1'b1), $urandom_range(0, 2),
            $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      runOp(1, ra, rb, expProduct(ra, rb), expLatency(rb, 1'b0), 0,
            $sformatf("rndFull%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
